// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the default memory-wait timeout.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  localparam int unsigned WAIT_LIMIT_DEFAULT = 15;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX has not produced yet. Register 0 never creates a dependency.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a 5-stage pipeline: load-use stalls, branch
// flushes, data-memory wait freezes with a timeout that halts the pipeline.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        ex_mem_write,
  output logic        mem_wb_bubble,
  output logic        mem_error,
  output logic [15:0] stall_cycles
);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [4:0] wait_next;
  logic       lu;
  logic       ms;

  load_use_detect u_lu (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (lu)
  );

  assign ms = (state != HALT) && mem_req && !mem_ready;

  // The widened increment keeps the compare correct even when WAIT_LIMIT
  // equals the 4-bit counter's wrap point.
  assign wait_next = {1'b0, wait_cnt} + 5'd1;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (state == HALT || ms) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      // The ID instruction is wrong-path, so a load-use match on it is moot.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= 4'd0;
      mem_error <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (ms) begin
            state    <= MEM_WAIT;
            wait_cnt <= 4'd0;
          end
        end
        MEM_WAIT: begin
          if (!ms) begin
            state    <= RUN;
            wait_cnt <= 4'd0;
          end else if (wait_next == 5'(WAIT_LIMIT)) begin
            // RUN entry cycle plus WAIT_LIMIT wait cycles have now elapsed.
            state     <= HALT;
            wait_cnt  <= 4'd0;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_next[3:0];
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
    end else if (!pc_write && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: a behavioural model
// predicts each cycle's outputs, which are queued and compared mid-cycle.
module tb_pipeline_hazard_controller;

  localparam int WL = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, branch_taken, mem_req, mem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write;
  logic        id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_error;
  logic [15:0] stall_cycles;

  pipeline_hazard_controller #(.WAIT_LIMIT(WL)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_write   (id_ex_write),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_write  (ex_mem_write),
    .mem_wb_bubble (mem_wb_bubble),
    .mem_error     (mem_error),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc, ifw, iff, idw, idb, exw, wbb, err, stall[15:0]}
  logic [23:0] obs;
  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                ex_mem_write, mem_wb_bubble, mem_error, stall_cycles};

  logic [23:0] sb_q[$];
  logic [23:0] exp_v;
  int checks = 0;
  int failures = 0;

  bit m_halt, m_err;
  int m_freeze, m_stall;

  task automatic model_reset();
    m_halt = 0; m_err = 0; m_freeze = 0; m_stall = 0;
    sb_q.delete();
  endtask

  // Apply one cycle of inputs, predict outputs and advance the model.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                       input logic [4:0] ert, input logic br, input logic mreq,
                       input logic mrdy);
    logic ms, lu;
    logic [6:0] c;
    id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
    branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    ms = !m_halt && mreq && !mrdy;
    lu = mr && (ert != 0) && (ert == rs || ert == rt);
    if (m_halt || ms)  c = 7'b0000001;
    else if (br)       c = 7'b1111110;
    else if (lu)       c = 7'b0001110;
    else               c = 7'b1101010;
    sb_q.push_back({c, m_err, 16'(m_stall)});
    if (!c[6] && m_stall < 65535) m_stall++;
    if (ms) begin
      m_freeze++;
      if (m_freeze == WL + 1) begin
        m_halt = 1;
        m_err  = 1;
      end
    end else begin
      m_freeze = 0;
    end
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between clock edges; the model is cleared to match.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    id_rs = 0; id_rt = 0; ex_mem_read = 0; ex_rt = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    idle();
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", obs, exp_v);
    end
    release_reset();
  endtask

  task automatic test_load_use();
    // rs match, then idle to observe the count, then rt match
    drive(5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL load_use_rs got=%h want=%h", obs, exp_v); end
    next_cycle();
    idle();
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL load_use_release got=%h want=%h", obs, exp_v); end
    next_cycle();
    drive(5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL load_use_rt got=%h want=%h", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_no_hazard();
    logic [4:0] tbl_rs[4] = '{5'd0, 5'd7, 5'd3, 5'd4};
    logic [4:0] tbl_rt[4] = '{5'd0, 5'd7, 5'd3, 5'd8};
    logic       tbl_mr[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] tbl_er[4] = '{5'd0, 5'd7, 5'd6, 5'd9};
    for (int i = 0; i < 4; i++) begin
      drive(tbl_rs[i], tbl_rt[i], tbl_mr[i], tbl_er[i], 1'b0, 1'b0, 1'b0);
      @(negedge clk); exp_v = sb_q.pop_front(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL no_hazard[%0d] got=%h want=%h", i, obs, exp_v); end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL branch_over_lu got=%h want=%h", obs, exp_v); end
    next_cycle();
    drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL branch_plain got=%h want=%h", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    // three frozen cycles (one with a branch that must lose), ready on the 4th
    for (int i = 0; i < 4; i++) begin
      drive(5'd5, 5'd0, 1'b1, 5'd5, (i == 1), 1'b1, (i == 3));
      @(negedge clk); exp_v = sb_q.pop_front(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL mem_wait[%0d] got=%h want=%h", i, obs, exp_v); end
      next_cycle();
    end
    // back in RUN: a lone load-use stalls exactly one cycle
    drive(5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mem_wait_after got=%h want=%h", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
      @(negedge clk); exp_v = sb_q.pop_front(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs, exp_v); end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    release_reset();
    for (int i = 0; i < 20; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); exp_v = sb_q.pop_front(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL timeout[%0d] got=%h want=%h", i, obs, exp_v); end
      next_cycle();
    end
    // HALT ignores a ready memory
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL halt_hold got=%h want=%h", obs, exp_v); end
    apply_reset();
    idle();
    exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL halt_async_reset got=%h want=%h", obs, exp_v); end
    release_reset();
    idle();
    @(negedge clk); exp_v = sb_q.pop_front(); checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL post_halt_run got=%h want=%h", obs, exp_v); end
    next_cycle();
  endtask

  task automatic test_saturation();
    int guard;
    apply_reset();
    release_reset();
    for (int i = 0; i < 16; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); exp_v = sb_q.pop_front(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL sat_enter[%0d] got=%h want=%h", i, obs, exp_v); end
      next_cycle();
    end
    guard = 0;
    while (m_stall < 65534 && guard < 70000) begin
      idle();
      @(negedge clk); exp_v = sb_q.pop_front();
      if (exp_v[15:0] >= 16'd65530) begin
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL sat_ramp got=%h want=%h", obs, exp_v); end
      end
      next_cycle();
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      @(negedge clk); exp_v = sb_q.pop_front(); checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL saturate[%0d] got=%h want=%h", i, obs, exp_v); end
      next_cycle();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    id_rs = 0; id_rt = 0; ex_mem_read = 0; ex_rt = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
    model_reset();
    #12;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
